// File: rtl/pht_update_sched_pkg.sv
// Shared types and the 2-bit saturating-counter rule for the branch predictor's PHT.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  pht_state_t;

    localparam pht_state_t PHT_WEAK_NT = 2'b01;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } pht_sched_state_e;

    // Taken moves toward strongly-taken, not-taken toward strongly-not-taken; both saturate.
    function automatic pht_state_t sat_update(pht_state_t ctr, logic taken);
        pht_state_t res;
        if (taken) res = (ctr == 2'b11) ? ctr : ctr + 2'b01;
        else       res = (ctr == 2'b00) ? ctr : ctr - 2'b01;
        return res;
    endfunction

endpackage

// File: rtl/pht_update_sched_if.sv
// Writeback event bus plus PHT write/read port, as seen by the update scheduler.
interface pht_update_sched_if
    import lc3b_types::*;
#(
    parameter int unsigned PC_W   = 4,
    parameter int unsigned HIST_W = 4
);
    localparam int unsigned IDX_W = PC_W + HIST_W;

    logic              wb_valid;
    lc3b_word          wb_pc;
    logic [HIST_W-1:0] wb_bhr;
    logic              wb_taken;
    logic              wb_stall;
    logic              pht_we;
    logic [IDX_W-1:0]  pht_index;
    pht_state_t        pht_wdata;
    pht_state_t        pht_rdata;

    modport master (
        output wb_valid, wb_pc, wb_bhr, wb_taken, pht_rdata,
        input  wb_stall, pht_we, pht_index, pht_wdata
    );

    modport slave (
        input  wb_valid, wb_pc, wb_bhr, wb_taken, pht_rdata,
        output wb_stall, pht_we, pht_index, pht_wdata
    );
endinterface

// File: rtl/pht_update_sched_fifo.sv
// Small circular FIFO of resolved-branch events {index, taken}; caller guarantees no overflow/underflow.
module br_event_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // Flush wins over any push/pop this cycle.
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once count says they are valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/pht_update_sched.sv
// PHT write-port owner: walks the table to weakly-not-taken after reset/clear, then drains queued branch updates.
module pht_update_sched
    import lc3b_types::*;
#(
    parameter int unsigned PC_W   = 4,
    parameter int unsigned HIST_W = 4,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pht_clear,
    pht_update_sched_if.slave       bus,
    output logic                    init_busy,
    output logic [$clog2(DEPTH):0]  q_count
);
    localparam int unsigned IDX_W = PC_W + HIST_W;
    localparam int unsigned ENT_W = IDX_W + 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    pht_sched_state_e  state_q, state_d;
    logic [IDX_W-1:0]  init_cnt_q, init_cnt_d;
    logic              push, pop;
    logic [ENT_W-1:0]  push_data, head;
    logic [CNT_W-1:0]  count;
    logic              unused_pc_bits;

    assign unused_pc_bits = ^bus.wb_pc[$bits(lc3b_word)-1:PC_W];

    // Stall looks only at registered occupancy, so a same-cycle pop never frees a slot.
    assign bus.wb_stall = (count == CNT_W'(DEPTH));
    assign push         = bus.wb_valid && !bus.wb_stall;
    assign push_data    = {bus.wb_pc[PC_W-1:0], bus.wb_bhr, bus.wb_taken};

    always_comb begin
        state_d       = state_q;
        init_cnt_d    = init_cnt_q;
        pop           = 1'b0;
        bus.pht_we    = 1'b0;
        bus.pht_index = head[ENT_W-1:1];
        bus.pht_wdata = sat_update(bus.pht_rdata, head[0]);
        case (state_q)
            S_INIT: begin
                bus.pht_we    = 1'b1;
                bus.pht_index = init_cnt_q;
                bus.pht_wdata = PHT_WEAK_NT;
                init_cnt_d    = init_cnt_q + IDX_W'(1);
                if (init_cnt_q == {IDX_W{1'b1}}) state_d = S_RUN;
            end
            S_RUN: begin
                if (count != '0) begin
                    bus.pht_we = 1'b1;
                    pop        = 1'b1;
                end
            end
            default: state_d = S_INIT;
        endcase
        if (pht_clear) begin
            state_d    = S_INIT;
            init_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    br_event_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (pht_clear),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign init_busy = (state_q == S_INIT);
    assign q_count   = count;

endmodule
